// File: rtl/key_event_decoder_if.sv
// Button event bundle between a debounced button source and its event decoder.
// The master drives the debounced level; the slave returns the level copy and event pulses.
interface key_event_decoder_if;
  logic btn_level;
  logic key_held;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic double_click;

  modport master (
    output btn_level,
    input  key_held,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  double_click
  );

  modport slave (
    input  btn_level,
    output key_held,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output repeat_pulse,
    output double_click
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat/double pulses.
// One shared counter times the long-press, auto-repeat and double-click windows.
module key_event_decoder #(
  parameter int unsigned LONG_CYC   = 100_000_000,
  parameter int unsigned REPEAT_CYC = 20_000_000,
  parameter int unsigned DCLICK_CYC = 30_000_000,
  parameter int unsigned CNT_W      = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  key_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPressed = 3'd1,
    StLheld   = 3'd2,
    StWait2   = 3'd3,
    StPress2  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] CntZero    = '0;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_q;
  logic             r_press;
  logic             r_release;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_double;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_rise;
  logic             w_fall;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_repeat_nxt;
  logic             w_double_nxt;

  assign w_rise = bus.btn_level & ~r_btn_q;
  assign w_fall = ~bus.btn_level & r_btn_q;

  // Edges are checked before timeouts so a same-cycle edge always wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_short_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_double_nxt  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = CntZero;
        if (w_rise) begin
          w_state_nxt = StPressed;
          w_press_nxt = 1'b1;
        end
      end

      StPressed: begin
        if (w_fall) begin
          w_state_nxt   = StWait2;
          w_cnt_nxt     = CntZero;
          w_release_nxt = 1'b1;
        end else if (r_cnt == LongLast) begin
          w_state_nxt = StLheld;
          w_cnt_nxt   = CntZero;
          w_long_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end

      StLheld: begin
        if (w_fall) begin
          w_state_nxt   = StIdle;
          w_cnt_nxt     = CntZero;
          w_release_nxt = 1'b1;
        end else if (r_cnt == RepeatLast) begin
          w_cnt_nxt    = CntZero;
          w_repeat_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end

      StWait2: begin
        if (w_rise) begin
          w_state_nxt = StPress2;
          w_cnt_nxt   = CntZero;
          w_press_nxt = 1'b1;
        end else if (r_cnt == DclickLast) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = CntZero;
          w_short_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end

      StPress2: begin
        if (w_fall) begin
          w_state_nxt   = StIdle;
          w_cnt_nxt     = CntZero;
          w_release_nxt = 1'b1;
          w_double_nxt  = 1'b1;
        end else if (r_cnt == LongLast) begin
          // Held too long: the earlier click is dropped and this becomes a long press.
          w_state_nxt = StLheld;
          w_cnt_nxt   = CntZero;
          w_long_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = CntZero;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_btn_q   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_double  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_btn_q   <= bus.btn_level;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_short   <= w_short_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_double  <= w_double_nxt;
    end
  end

  // The sampled level doubles as the held indication.
  assign bus.key_held      = r_btn_q;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.short_press   = r_short;
  assign bus.long_press    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.double_click  = r_double;

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed bench for key_event_decoder against a timestamp-based reference model.
module tb_key_event_decoder;

  localparam int unsigned LongCyc   = 20;
  localparam int unsigned RepeatCyc = 8;
  localparam int unsigned DclickCyc = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  key_event_decoder_if bus_if ();

  key_event_decoder #(
    .LONG_CYC  (LongCyc),
    .REPEAT_CYC(RepeatCyc),
    .DCLICK_CYC(DclickCyc),
    .CNT_W     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers when the current press began and when the last
  // short click was released, and derives every pulse from elapsed time.
  int   m_n;
  int   m_press_t;
  int   m_rel_t;
  logic m_prev;
  logic m_pending;
  logic m_second;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at model cycle %0d: got %0h expected %0h", tag, m_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n       = 0;
    m_press_t = 0;
    m_rel_t   = 0;
    m_prev    = 1'b0;
    m_pending = 1'b0;
    m_second  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_held"}, 32'(bus_if.key_held), 32'd0);
    check_eq({tag, "_pulses"}, 32'({bus_if.press_pulse, bus_if.release_pulse,
                                    bus_if.short_press, bus_if.long_press,
                                    bus_if.repeat_pulse, bus_if.double_click}), 32'd0);
  endtask

  // Drive one level for one clock, then compare all outputs with the model.
  task automatic step(input logic b);
    logic e_press, e_rel, e_short, e_long, e_rep, e_dbl;
    int   d;
    @(negedge clk);
    bus_if.btn_level = b;
    @(posedge clk);
    #1;
    e_press = b & ~m_prev;
    e_rel   = ~b & m_prev;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    e_dbl   = 1'b0;
    d       = m_n - m_press_t;
    if (e_press) begin
      m_press_t = m_n;
      m_second  = m_pending && ((m_n - m_rel_t) <= int'(DclickCyc));
      m_pending = 1'b0;
    end else if (b) begin
      if (d == int'(LongCyc)) e_long = 1'b1;
      else if (d > int'(LongCyc) && ((d - int'(LongCyc)) % int'(RepeatCyc)) == 0) e_rep = 1'b1;
    end else if (e_rel) begin
      if (d <= int'(LongCyc)) begin
        if (m_second) e_dbl = 1'b1;
        else begin
          m_pending = 1'b1;
          m_rel_t   = m_n;
        end
      end
      m_second = 1'b0;
    end else if (m_pending && (m_n - m_rel_t) == int'(DclickCyc)) begin
      e_short   = 1'b1;
      m_pending = 1'b0;
    end
    m_prev = b;
    check_eq("key_held", 32'(bus_if.key_held), 32'(b));
    check_eq("press_pulse", 32'(bus_if.press_pulse), 32'(e_press));
    check_eq("release_pulse", 32'(bus_if.release_pulse), 32'(e_rel));
    check_eq("short_press", 32'(bus_if.short_press), 32'(e_short));
    check_eq("long_press", 32'(bus_if.long_press), 32'(e_long));
    check_eq("repeat_pulse", 32'(bus_if.repeat_pulse), 32'(e_rep));
    check_eq("double_click", 32'(bus_if.double_click), 32'(e_dbl));
    m_n++;
  endtask

  task automatic run(input logic b, input int cycles);
    for (int i = 0; i < cycles; i++) step(b);
  endtask

  // Asynchronous reset applied mid-cycle; the level b is held throughout and after release.
  task automatic do_reset(input logic b);
    @(posedge clk);
    #2;
    bus_if.btn_level = b;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("rst_hold");
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    bus_if.btn_level = 1'b0;
    rst_n = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    run(1'b0, 3);
    // Short click, long hold with repeats, double click.
    run(1'b1, 5);  run(1'b0, 20);
    run(1'b1, 40); run(1'b0, 20);
    run(1'b1, 3);  run(1'b0, 4); run(1'b1, 3); run(1'b0, 20);
    // Second rise exactly on the last window cycle, then one cycle too late.
    run(1'b1, 3);  run(1'b0, 10); run(1'b1, 3); run(1'b0, 20);
    run(1'b1, 3);  run(1'b0, 11); run(1'b1, 3); run(1'b0, 20);
    // Release exactly at the long threshold, and second press held into a long press.
    run(1'b1, 20); run(1'b0, 20);
    run(1'b1, 21); run(1'b0, 20);
    run(1'b1, 2);  run(1'b0, 3); run(1'b1, 30); run(1'b0, 20);

    // Reset inside the double-click window: no late short_press.
    run(1'b1, 3);  run(1'b0, 4);
    do_reset(1'b0);
    run(1'b0, 20);

    // Button held through reset release is a fresh press.
    run(1'b1, 5);
    do_reset(1'b1);
    run(1'b1, 25); run(1'b0, 20);

    for (int s = 0; s < 60; s++) begin
      run(1'b1, int'($urandom_range(1, 45)));
      run(1'b0, int'($urandom_range(1, 14)));
    end
    run(1'b0, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
